// File: rtl/render_pkg.sv
// Shared types and constants for shape-renderer frame sequencers.
package render_pkg;

  localparam int unsigned X_W        = 11;
  localparam int unsigned Y_W        = 12;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned PROG_WORDS = 5;
  localparam int unsigned IDX_W      = 3;

  localparam logic [IDX_W-1:0] IDX_CX    = 3'd0;
  localparam logic [IDX_W-1:0] IDX_CY    = 3'd1;
  localparam logic [IDX_W-1:0] IDX_W_AX  = 3'd2;
  localparam logic [IDX_W-1:0] IDX_H     = 3'd3;
  localparam logic [IDX_W-1:0] IDX_COLOR = 3'd4;

  typedef enum logic [1:0] {IDLE, PROG, SCAN, DONE} state_e;

  typedef struct packed {
    logic [X_W-1:0]    cx;
    logic [Y_W-1:0]    cy;
    logic [X_W-1:0]    w;
    logic [Y_W-1:0]    h;
    logic [DATA_W-1:0] color;
  } shape_cmd_t;

  // Counter width for a 0..n-1 range, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Renderer programming word for a given index.
  function automatic logic [DATA_W-1:0] prog_word(input shape_cmd_t cmd, input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_CX:    prog_word = DATA_W'(cmd.cx);
      IDX_CY:    prog_word = DATA_W'(cmd.cy);
      IDX_W_AX:  prog_word = DATA_W'(cmd.w);
      IDX_H:     prog_word = DATA_W'(cmd.h);
      IDX_COLOR: prog_word = cmd.color;
      default:   prog_word = '0;
    endcase
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Column-major raster coordinate counter: y is the fast axis, x the slow one.
// Holds at the final pixel; the owner clears it before the next frame.
module raster_counter
  import render_pkg::*;
#(
  parameter  int unsigned H_RES = 1080,
  parameter  int unsigned V_RES = 2160,
  localparam int unsigned XW    = cnt_width(H_RES),
  localparam int unsigned YW    = cnt_width(V_RES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clear,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    last = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (en && !last) begin
      if (y_q != YW'(V_RES - 1)) begin
        y_d = y_q + YW'(1);
      end else begin
        y_d = '0;
        x_d = x_q + XW'(1);
      end
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/ellipse_frame_sequencer.sv
// Per-frame sequencer for one ellipse_renderer: programs the shape words,
// then raster-scans every pixel with the background colour.
module ellipse_frame_sequencer
  import render_pkg::*;
#(
  parameter int unsigned H_RES = 1080,
  parameter int unsigned V_RES = 2160
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_cx,
  input  logic [Y_W-1:0]    cmd_cy,
  input  logic [X_W-1:0]    cmd_w,
  input  logic [Y_W-1:0]    cmd_h,
  input  logic [DATA_W-1:0] cmd_color,
  input  logic [DATA_W-1:0] bg_color,
  input  logic              scan_en,
  output logic              program_out,
  output logic [X_W-1:0]    x_out,
  output logic [Y_W-1:0]    y_out,
  output logic [DATA_W-1:0] data_out,
  output logic              scan_valid,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned CXW = cnt_width(H_RES);
  localparam int unsigned CYW = cnt_width(V_RES);

  if (H_RES == 0 || V_RES == 0 || H_RES > 2048 || V_RES > 4096) begin : g_bad_params
    $error("ellipse_frame_sequencer: H_RES must be 1..2048 and V_RES 1..4096");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  shape_cmd_t        cmd_q, cmd_d;
  logic [DATA_W-1:0] bg_q, bg_d;

  logic           cnt_en, cnt_clear, cnt_last;
  logic [CXW-1:0] cnt_x;
  logic [CYW-1:0] cnt_y;

  raster_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_raster (
    .clk   (clk),
    .rst   (rst),
    .en    (cnt_en),
    .clear (cnt_clear),
    .x     (cnt_x),
    .y     (cnt_y),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cmd_q   <= '0;
      bg_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cmd_q   <= cmd_d;
      bg_q    <= bg_d;
    end
  end

  // Next state plus renderer-port drive; rst gates cmd_ready so nothing is accepted in a reset cycle.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cmd_d       = cmd_q;
    bg_d        = bg_q;
    cnt_en      = 1'b0;
    cnt_clear   = 1'b0;
    cmd_ready   = 1'b0;
    program_out = 1'b0;
    x_out       = '0;
    y_out       = '0;
    data_out    = '0;
    scan_valid  = 1'b0;
    frame_done  = 1'b0;
    busy        = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid) begin
          cmd_d   = '{cx: cmd_cx, cy: cmd_cy, w: cmd_w, h: cmd_h, color: cmd_color};
          idx_d   = '0;
          state_d = PROG;
        end
      end
      PROG: begin
        program_out = 1'b1;
        y_out       = Y_W'(idx_q);
        data_out    = prog_word(cmd_q, idx_q);
        if (idx_q == IDX_W'(PROG_WORDS - 1)) begin
          cnt_clear = 1'b1;
          bg_d      = bg_color;
          state_d   = SCAN;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      SCAN: begin
        x_out      = X_W'(cnt_x);
        y_out      = Y_W'(cnt_y);
        data_out   = bg_q;
        scan_valid = scan_en;
        cnt_en     = scan_en;
        if (scan_en && cnt_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

endmodule
